xor_swap_seq: RTL
=================

Name: xor_swap_seq

Overview:
- Sequential, handshaked swap engine. It accepts an operand pair (a, b) and exchanges the pair using the three-step XOR algorithm (a^=b; b^=a; a^=b) with no temporary register.
- It returns the swapped pair on a valid/ready output port.
- It is the registered, flow-controlled counterpart of the team's combinational swap unit. It sits between a producer and a consumer that both need backpressure.
- It also keeps a count of completed swaps for debug.

Parameters:
- WIDTH, 4, bit width of each operand and result.
- CNT_W, 8, width of the completed-swap counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  producer presents a valid operand pair.
- in_ready  output  1  engine can accept a pair this cycle.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- out_valid  output  1  swapped result available.
- out_ready  input  1  consumer accepts the result this cycle.
- out_a  output  WIDTH  swapped a (equals captured b).
- out_b  output  WIDTH  swapped b (equals captured a).
- busy  output  1  high in any state other than IDLE.
- swap_count  output  CNT_W  number of results handed off since reset.

Behaviour:
- Reset: on a rising edge with rst_n=0 the engine takes the reset values regardless of state, including mid-swap. Any in-flight pair is discarded and no result is emitted for it.
  - State goes to IDLE; internal ra, rb, out_a, out_b are 0.
  - out_valid=0, busy=0, swap_count=0.
  - in_ready=1 on the first cycle after reset deasserts.
- States: IDLE, S1, S2, S3, DONE. Encoding is 3 bits, held in the shared package.
- IDLE: in_ready=1. If in_valid=1, capture ra<=in_a, rb<=in_b and go to S1. Otherwise stay.
- S1: ra<=ra^rb, then go to S2.
- S2: rb<=rb^ra (using the updated ra), then go to S3.
- S3: ra<=ra^rb, then go to DONE.
- DONE: out_valid=1, out_a=ra, out_b=rb.
  - If out_ready=1: swap_count increments and the engine goes to IDLE.
  - Otherwise it stays in DONE with outputs held stable. Values must not change while out_valid=1 and out_ready=0.
- in_ready is 0 in S1..DONE. in_a/in_b are ignored outside IDLE, and in_valid outside IDLE has no effect.
- Latency: handshake accepted at edge N. out_valid=1 in the cycle following edge N+3, i.e. after 4 edges in total. With out_ready held high, throughput is 1 pair per 5 cycles.
- No bypass from DONE to IDLE-accept in the same cycle. in_ready rises only in the cycle after the output handshake.
- out_a/out_b are registered (ra/rb). They show intermediate XOR values while busy; consumers must qualify them with out_valid.
- Arithmetic: all XORs are WIDTH bits, with no carries.
  - a==b: the sequence yields a=b (intermediate ra=0), which is correct and needs no special case.
  - a or b = 0 and all-ones operands need no special handling.
- swap_count wraps modulo 2^CNT_W: 2^CNT_W-1 followed by 0.
- busy = (state != IDLE).

Decomposition:
- Package xor_swap_pkg: state typedef/constants (IDLE=0, S1=1, S2=2, S3=3, DONE=4) and the default WIDTH/CNT_W constants.
- Optional sub-module xor_swap_dp: holds ra/rb and applies the step selected by a 2-bit step code from the FSM. The FSM plus counter stay in the top module.

Test Plan:
- Reset, then in_a=1, in_b=0, in_valid pulse, out_ready=1 → out_valid at the 4th edge after accept, out_a=0, out_b=1, swap_count=1, busy low the next cycle.
- Equal operands in_a=5, in_b=5 → out_a=5, out_b=5; then in_a=0, in_b=0 → 0/0; then in_a=15, in_b=0 → 0/15.
- Backpressure: in_a=9, in_b=6 with out_ready=0 for 7 cycles → out_valid stays 1, out_a=6, out_b=9 stable, in_ready=0, in_valid retries ignored. Raise out_ready → count increments once, in_ready=1 the next cycle.
- Reset mid-op: accept in_a=3, in_b=12, assert rst_n=0 during S2 → next cycle out_valid=0, busy=0, swap_count=0, out_a=out_b=0. No stale result appears afterwards.
- Back-to-back: in_valid held high with 4 pairs and out_ready=1 → 4 correct results at 5-cycle spacing, swap_count=4.
- Counter wrap (CNT_W=2): 5 completed swaps → swap_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/xor_swap_pkg.sv
// Shared types and defaults for the sequential XOR swap engine.
// Holds the FSM state encoding and the datapath step codes.
package xor_swap_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    DONE = 3'd4
  } state_t;

  // One-hot-free step code issued by the FSM to the datapath each cycle.
  typedef enum logic [1:0] {
    STEP_HOLD  = 2'd0,
    STEP_LOAD  = 2'd1,
    STEP_A_XOR = 2'd2,
    STEP_B_XOR = 2'd3
  } step_t;

endpackage

// File: rtl/xor_swap_dp.sv
// Operand register pair for the XOR swap; applies one step per clock.
// No temporary register: every update is a single in-place XOR.
module xor_swap_dp
  import xor_swap_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  step_t            step,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] ra,
  output logic [WIDTH-1:0] rb
);

  logic [WIDTH-1:0] ra_reg;
  logic [WIDTH-1:0] rb_reg;
  logic [WIDTH-1:0] ra_next;
  logic [WIDTH-1:0] rb_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign ra_next[gi] = (step == STEP_LOAD)  ? in_a[gi] :
                           (step == STEP_A_XOR) ? (ra_reg[gi] ^ rb_reg[gi]) :
                                                  ra_reg[gi];
      assign rb_next[gi] = (step == STEP_LOAD)  ? in_b[gi] :
                           (step == STEP_B_XOR) ? (rb_reg[gi] ^ ra_reg[gi]) :
                                                  rb_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ra_reg <= '0;
      rb_reg <= '0;
    end else begin
      ra_reg <= ra_next;
      rb_reg <= rb_next;
    end
  end

  assign ra = ra_reg;
  assign rb = rb_reg;

endmodule

// File: rtl/xor_swap_seq.sv
// Handshaked sequential swap engine: accept (a,b), run three XOR steps,
// present (b,a) until the consumer takes it, and count handed-off results.
module xor_swap_seq
  import xor_swap_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             busy,
  output logic [CNT_W-1:0] swap_count
);

  state_t           state_reg;
  state_t           state_next;
  step_t            step;
  logic [CNT_W-1:0] count_reg;
  logic             hand_off;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (hand_off) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    step       = STEP_HOLD;
    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          step       = STEP_LOAD;
          state_next = S1;
        end
      end
      S1: begin
        step       = STEP_A_XOR;
        state_next = S2;
      end
      S2: begin
        step       = STEP_B_XOR;
        state_next = S3;
      end
      S3: begin
        step       = STEP_A_XOR;
        state_next = DONE;
      end
      DONE: begin
        // Return to IDLE only; a new pair is taken the cycle after hand-off.
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  xor_swap_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk  (clk),
    .rst_n(rst_n),
    .step (step),
    .in_a (in_a),
    .in_b (in_b),
    .ra   (out_a),
    .rb   (out_b)
  );

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign busy       = (state_reg != IDLE);
  assign hand_off   = out_valid && out_ready;
  assign swap_count = count_reg;

endmodule
